// File: rtl/usbf_tx_sched.sv
// usbf_tx_sched: transmit scheduler for the USB function packet assembler.
// Arbitrates handshake and data-packet requests, drives the assembler strobes,
// counts payload bytes, detects packet end on the UTMI side, inserts an
// inter-packet gap and aborts the packet when tx_ready stays low too long.
//
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   i_hs_req/i_hs_pid           handshake request (ACK/NAK/STALL/NYET)
//   o_hs_ack                    handshake accepted (pulse)
//   i_dat_req/i_dat_pid/i_dat_len  data-packet request, PID and byte length
//   o_dat_ack                   data request accepted (pulse)
//   o_pkt_done / o_tx_err       packet sent / watchdog abort (pulses)
//   o_busy                      high whenever not idle
//   o_send_token/o_token_pid_sel   handshake strobe and PID to the assembler
//   o_send_data/o_data_pid_sel/o_send_zero_length  payload level, PID, ZLP flag
//   i_rd_next                   one pulse per payload byte consumed
//   i_tx_ready, i_tx_valid      UTMI handshake signals
module usbf_tx_sched #(
    parameter int unsigned IPG_CYCLES = 4,
    parameter int unsigned LEN_W      = 11,
    parameter int unsigned TO_CYCLES  = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_hs_req,
    input  logic [1:0]       i_hs_pid,
    output logic             o_hs_ack,
    input  logic             i_dat_req,
    input  logic [1:0]       i_dat_pid,
    input  logic [LEN_W-1:0] i_dat_len,
    output logic             o_dat_ack,
    output logic             o_pkt_done,
    output logic             o_tx_err,
    output logic             o_busy,
    output logic             o_send_token,
    output logic [1:0]       o_token_pid_sel,
    output logic             o_send_data,
    output logic [1:0]       o_data_pid_sel,
    output logic             o_send_zero_length,
    input  logic             i_rd_next,
    input  logic             i_tx_ready,
    input  logic             i_tx_valid
);

    localparam int unsigned CNT_W = 8;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HS     = 3'd1;
    localparam logic [2:0] S_DPRE   = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_DFLUSH = 3'd4;
    localparam logic [2:0] S_GAP    = 3'd5;

    logic [2:0]       r_state;
    logic [LEN_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_wdog;
    logic [CNT_W-1:0] r_gap;
    logic             r_txv_d;

    logic [2:0]       w_state_nxt;
    logic [LEN_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_wdog_nxt;
    logic [CNT_W-1:0] w_gap_nxt;
    logic             w_hs_ack;
    logic             w_dat_ack;
    logic             w_pkt_done;
    logic             w_tx_err;
    logic             w_send_token;
    logic [1:0]       w_token_pid;
    logic             w_send_data;
    logic [1:0]       w_data_pid;
    logic             w_szl;
    logic             w_wd_run;
    logic             w_wd_expire;

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_gap_nxt    = r_gap;
        w_hs_ack     = 1'b0;
        w_dat_ack    = 1'b0;
        w_pkt_done   = 1'b0;
        w_tx_err     = 1'b0;
        w_send_token = 1'b0;
        w_token_pid  = o_token_pid_sel;
        w_send_data  = o_send_data;
        w_data_pid   = o_data_pid_sel;
        w_szl        = o_send_zero_length;

        // Watchdog only runs in transmit states; it sits at 0 elsewhere, which
        // gives the clear-on-entry behaviour for HS and DATA for free.
        w_wd_run    = (r_state == S_HS) || (r_state == S_DATA) || (r_state == S_DFLUSH);
        w_wd_expire = w_wd_run && !i_tx_ready && (r_wdog == CNT_W'(TO_CYCLES - 1));
        if (!w_wd_run || i_tx_ready) begin
            w_wdog_nxt = '0;
        end else begin
            w_wdog_nxt = r_wdog + CNT_W'(1);
        end

        case (r_state)
            S_IDLE: begin
                if (i_hs_req) begin
                    w_hs_ack     = 1'b1;
                    w_send_token = 1'b1;
                    w_token_pid  = i_hs_pid;
                    w_state_nxt  = S_HS;
                end else if (i_dat_req) begin
                    w_dat_ack   = 1'b1;
                    w_data_pid  = i_dat_pid;
                    w_cnt_nxt   = i_dat_len;
                    w_szl       = (i_dat_len == '0);
                    w_state_nxt = S_DPRE;
                end
            end
            S_HS: begin
                if (w_wd_expire) begin
                    w_tx_err    = 1'b1;
                    w_state_nxt = S_GAP;
                end else if (i_tx_ready) begin
                    w_pkt_done  = 1'b1;
                    w_state_nxt = S_GAP;
                end
            end
            // One spacer cycle so the assembler sees send_zero_length first
            S_DPRE: begin
                w_send_data = 1'b1;
                w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (w_wd_expire) begin
                    w_tx_err    = 1'b1;
                    w_send_data = 1'b0;
                    w_szl       = 1'b0;
                    w_state_nxt = S_GAP;
                end else if ((r_cnt == '0) || (i_rd_next && (r_cnt == LEN_W'(1)))) begin
                    w_cnt_nxt   = '0;
                    w_send_data = 1'b0;
                    w_szl       = 1'b0;
                    w_wdog_nxt  = '0;
                    w_state_nxt = S_DFLUSH;
                end else if (i_rd_next) begin
                    w_cnt_nxt = r_cnt - LEN_W'(1);
                end
            end
            // Wait for tx_valid to fall after the CRC bytes
            S_DFLUSH: begin
                if (w_wd_expire) begin
                    w_tx_err    = 1'b1;
                    w_state_nxt = S_GAP;
                end else if (r_txv_d && !i_tx_valid) begin
                    w_pkt_done  = 1'b1;
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap == CNT_W'(IPG_CYCLES - 1)) begin
                    w_gap_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gap_nxt = r_gap + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state            <= S_IDLE;
            r_cnt              <= '0;
            r_wdog             <= '0;
            r_gap              <= '0;
            r_txv_d            <= 1'b0;
            o_hs_ack           <= 1'b0;
            o_dat_ack          <= 1'b0;
            o_pkt_done         <= 1'b0;
            o_tx_err           <= 1'b0;
            o_busy             <= 1'b0;
            o_send_token       <= 1'b0;
            o_token_pid_sel    <= '0;
            o_send_data        <= 1'b0;
            o_data_pid_sel     <= '0;
            o_send_zero_length <= 1'b0;
        end else begin
            r_state            <= w_state_nxt;
            r_cnt              <= w_cnt_nxt;
            r_wdog             <= w_wdog_nxt;
            r_gap              <= w_gap_nxt;
            r_txv_d            <= i_tx_valid;
            o_hs_ack           <= w_hs_ack;
            o_dat_ack          <= w_dat_ack;
            o_pkt_done         <= w_pkt_done;
            o_tx_err           <= w_tx_err;
            o_busy             <= (w_state_nxt != S_IDLE);
            o_send_token       <= w_send_token;
            o_token_pid_sel    <= w_token_pid;
            o_send_data        <= w_send_data;
            o_data_pid_sel     <= w_data_pid;
            o_send_zero_length <= w_szl;
        end
    end

endmodule

// File: tb/tb_usbf_tx_sched.sv
// tb_usbf_tx_sched: self-checking bench for usbf_tx_sched. A request table is
// run first, then hand-written sequences for cycle timing, arbitration,
// watchdog and mid-packet reset. Completion events are checked against a
// scoreboard queue filled when each request is driven.
module tb_usbf_tx_sched;

    localparam int unsigned IPG   = 4;
    localparam int unsigned LEN_W = 11;
    localparam int unsigned TO    = 255;

    logic             clk;
    logic             rst;
    logic             hs_req;
    logic [1:0]       hs_pid;
    logic             hs_ack;
    logic             dat_req;
    logic [1:0]       dat_pid;
    logic [LEN_W-1:0] dat_len;
    logic             dat_ack;
    logic             pkt_done;
    logic             tx_err;
    logic             busy;
    logic             send_token;
    logic [1:0]       token_pid_sel;
    logic             send_data;
    logic [1:0]       data_pid_sel;
    logic             szl;
    logic             rd_next;
    logic             tx_ready;
    logic             tx_valid;

    usbf_tx_sched #(.IPG_CYCLES(IPG), .LEN_W(LEN_W), .TO_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .i_hs_req(hs_req), .i_hs_pid(hs_pid), .o_hs_ack(hs_ack),
        .i_dat_req(dat_req), .i_dat_pid(dat_pid), .i_dat_len(dat_len), .o_dat_ack(dat_ack),
        .o_pkt_done(pkt_done), .o_tx_err(tx_err), .o_busy(busy),
        .o_send_token(send_token), .o_token_pid_sel(token_pid_sel),
        .o_send_data(send_data), .o_data_pid_sel(data_pid_sel),
        .o_send_zero_length(szl),
        .i_rd_next(rd_next), .i_tx_ready(tx_ready), .i_tx_valid(tx_valid)
    );

    typedef struct {
        bit       is_hs;
        bit [1:0] pid;
        int       len;
        int       rdy_dly;   // hs: cycles before tx_ready; data: 0 = tx_ready high, else low
        bit       rd_en;
        bit       exp_err;
        int       exp_sd;    // expected send_data high cycles
    } vec_t;

    typedef struct {
        bit       is_hs;
        bit [1:0] pid;
        bit       err;
        int       sd;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[9];
    int   n_chk = 0;
    int   n_err = 0;
    int   n_events = 0;
    int   sd_cnt = 0;
    int   tail = 0;
    bit   rd_en = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Assembler model plus scoreboard, sampled on the falling edge
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            rd_next  = 1'b0;
            tx_valid = 1'b0;
            tail     = 0;
            sd_cnt   = 0;
        end else begin
            rd_next = send_data && rd_en;
            if (send_data) begin
                tx_valid = 1'b1;
                tail     = 2;
            end else if (tail > 0) begin
                tail--;
                if (tail == 0) tx_valid = 1'b0;
            end
            if (send_data) sd_cnt++;
            if (pkt_done || tx_err) begin
                n_events++;
                if (sb.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL sb_unexpected_event act=done%0d_err%0d exp=none", pkt_done, tx_err);
                end else begin
                    e = sb.pop_front();
                    chk("ev_err", 32'(tx_err), 32'(e.err));
                    chk("ev_done", 32'(pkt_done), 32'(!e.err));
                    chk("ev_pid", e.is_hs ? 32'(token_pid_sel) : 32'(data_pid_sel), 32'(e.pid));
                    chk("ev_sd_cycles", 32'(sd_cnt), 32'(e.sd));
                end
                sd_cnt = 0;
            end
        end
    end

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 20 && busy; i++) tick();
        chk(nm, 32'(busy), 0);
    endtask

    task automatic wait_event(input string nm, input int n0);
        for (int i = 0; i < 3000 && n_events == n0; i++) tick();
        chk(nm, 32'(n_events - n0), 1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n0;
        sb.push_back('{v.is_hs, v.pid, v.exp_err, v.exp_sd});
        rd_en = v.rd_en;
        if (v.is_hs) begin
            tx_ready = 1'b0;
            hs_pid   = v.pid;
            hs_req   = 1'b1;
        end else begin
            tx_ready = (v.rdy_dly == 0);
            dat_pid  = v.pid;
            dat_len  = LEN_W'(v.len);
            dat_req  = 1'b1;
        end
        n0 = n_events;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (hs_ack || dat_ack) break;
        end
        chk($sformatf("v%0d_ack", idx), v.is_hs ? 32'(hs_ack) : 32'(dat_ack), 1);
        chk($sformatf("v%0d_busy", idx), 32'(busy), 1);
        if (v.is_hs) begin
            chk($sformatf("v%0d_token", idx), 32'(send_token), 1);
            chk($sformatf("v%0d_tpid", idx), 32'(token_pid_sel), 32'(v.pid));
        end else begin
            chk($sformatf("v%0d_szl", idx), 32'(szl), 32'(v.len == 0));
            chk($sformatf("v%0d_dpid", idx), 32'(data_pid_sel), 32'(v.pid));
        end
        hs_req  = 1'b0;
        dat_req = 1'b0;
        if (v.is_hs) begin
            repeat (v.rdy_dly) tick();
            tx_ready = 1'b1;
        end
        wait_event($sformatf("v%0d_event", idx), n0);
        tx_ready = 1'b1;
        wait_idle($sformatf("v%0d_idle", idx));
    endtask

    initial begin
        int n;
        int n0;
        vecs[0] = '{1'b1, 2'd0, 0,    0,   1'b0, 1'b0, 0};
        vecs[1] = '{1'b1, 2'd1, 0,    5,   1'b0, 1'b0, 0};
        vecs[2] = '{1'b1, 2'd3, 0,    254, 1'b0, 1'b0, 0};
        vecs[3] = '{1'b1, 2'd2, 0,    255, 1'b0, 1'b1, 0};
        vecs[4] = '{1'b0, 2'd0, 1,    0,   1'b1, 1'b0, 1};
        vecs[5] = '{1'b0, 2'd2, 7,    0,   1'b1, 1'b0, 7};
        vecs[6] = '{1'b0, 2'd3, 0,    0,   1'b1, 1'b0, 1};
        vecs[7] = '{1'b0, 2'd1, 4,    1,   1'b0, 1'b1, 255};
        vecs[8] = '{1'b0, 2'd2, 2047, 0,   1'b1, 1'b0, 2047};

        rst = 1'b0; hs_req = 0; hs_pid = 0; dat_req = 0; dat_pid = 0; dat_len = '0;
        tx_ready = 1'b1;
        repeat (3) tick();
        chk("rst_outputs", 32'({hs_ack, dat_ack, pkt_done, tx_err, busy, send_token,
                                token_pid_sel, send_data, data_pid_sel, szl}), 0);
        rst = 1'b1;
        tick();

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Handshake cycle timing
        sb.push_back('{1'b1, 2'd2, 1'b0, 0});
        tx_ready = 1'b0; hs_pid = 2'd2; hs_req = 1'b1;
        tick();
        chk("hs_ack", 32'(hs_ack), 1);
        chk("hs_token", 32'(send_token), 1);
        chk("hs_tpid", 32'(token_pid_sel), 2);
        chk("hs_busy", 32'(busy), 1);
        hs_req = 1'b0;
        tick();
        chk("hs_token_1cyc", 32'(send_token), 0);
        tick();
        tx_ready = 1'b1;
        tick();
        chk("hs_done_after_rdy", 32'(pkt_done), 1);
        repeat (3) tick();
        chk("hs_gap_busy", 32'(busy), 1);
        tick();
        chk("hs_gap_end", 32'(busy), 0);

        // Data packet of 5 bytes
        sb.push_back('{1'b0, 2'd1, 1'b0, 5});
        rd_en = 1'b1; dat_pid = 2'd1; dat_len = LEN_W'(5); dat_req = 1'b1;
        tick();
        chk("d5_ack", 32'(dat_ack), 1);
        chk("d5_sd_pre", 32'(send_data), 0);
        chk("d5_szl", 32'(szl), 0);
        dat_req = 1'b0;
        tick();
        chk("d5_sd_rise", 32'(send_data), 1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick(); n++;
            if (!send_data) break;
        end
        chk("d5_sd_len", 32'(n), 5);
        chk("d5_dpid", 32'(data_pid_sel), 1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick(); n++;
            if (pkt_done) break;
        end
        chk("d5_done_lat", 32'(n), 2);
        wait_idle("d5_idle");

        // Zero-length data packet
        sb.push_back('{1'b0, 2'd0, 1'b0, 1});
        dat_pid = 2'd0; dat_len = '0; dat_req = 1'b1;
        tick();
        chk("zlp_szl_pre", 32'(szl), 1);
        chk("zlp_sd_pre", 32'(send_data), 0);
        dat_req = 1'b0;
        tick();
        chk("zlp_sd", 32'(send_data), 1);
        chk("zlp_szl", 32'(szl), 1);
        tick();
        chk("zlp_sd_fall", 32'(send_data), 0);
        chk("zlp_szl_fall", 32'(szl), 0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick(); n++;
            if (pkt_done) break;
        end
        chk("zlp_done_lat", 32'(n), 2);
        wait_idle("zlp_idle");

        // Simultaneous requests: handshake first, data after the gap
        sb.push_back('{1'b1, 2'd3, 1'b0, 0});
        sb.push_back('{1'b0, 2'd2, 1'b0, 1});
        hs_pid = 2'd3; hs_req = 1'b1;
        dat_pid = 2'd2; dat_len = LEN_W'(1); dat_req = 1'b1;
        tick();
        chk("arb_hs_ack", 32'(hs_ack), 1);
        chk("arb_dat_wait", 32'(dat_ack), 0);
        hs_req = 1'b0;
        tick();
        chk("arb_hs_done", 32'(pkt_done), 1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick(); n++;
            if (dat_ack) break;
        end
        chk("arb_dat_ack_gap", 32'(n), IPG + 1);
        dat_req = 1'b0;
        n0 = n_events;
        wait_event("arb_dat_event", n0);
        wait_idle("arb_idle");

        // Watchdog abort in DATA
        sb.push_back('{1'b0, 2'd1, 1'b1, TO});
        tx_ready = 1'b0; rd_en = 1'b0;
        dat_pid = 2'd1; dat_len = LEN_W'(3); dat_req = 1'b1;
        tick();
        dat_req = 1'b0;
        tick();
        chk("wd_sd_rise", 32'(send_data), 1);
        n = 0;
        for (int i = 0; i < 400; i++) begin
            tick(); n++;
            if (tx_err) break;
        end
        chk("wd_err_lat", 32'(n), TO);
        chk("wd_sd_drop", 32'(send_data), 0);
        chk("wd_no_done", 32'(pkt_done), 0);
        repeat (3) tick();
        chk("wd_gap_busy", 32'(busy), 1);
        tick();
        chk("wd_idle", 32'(busy), 0);
        tx_ready = 1'b1;

        // Reset mid-DATA with three bytes left
        rd_en = 1'b1; dat_pid = 2'd3; dat_len = LEN_W'(5); dat_req = 1'b1;
        tick();
        dat_req = 1'b0;
        tick();
        tick();
        tick();
        n0 = n_events;
        #2;
        rst = 1'b0;
        #1;
        chk("rst_mid_outputs", 32'({hs_ack, dat_ack, pkt_done, tx_err, busy, send_token,
                                    token_pid_sel, send_data, data_pid_sel, szl}), 0);
        tick();
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_mid_no_event", 32'(n_events - n0), 0);
        run_vec(vecs[1], 100);

        chk("sb_drained", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/usbf_tx_sched.md
# usbf_tx_sched

Transmit scheduler for the USB function core's packet assembler. Accepts handshake requests (ACK/NAK/STALL/NYET) and data-packet requests (DATA0/1/2/MDATA, with byte length) from the protocol engine. Arbitrates between the two request types and drives the assembler's send_token / send_data / send_zero_length strobes with correct cycle alignment. Counts payload bytes via rd_next, detects packet end from the UTMI side, and enforces an inter-packet gap and a tx_ready watchdog.

## Interface
- IPG_CYCLES, 4: idle cycles inserted after every packet before the next is accepted (1..255).
- LEN_W, 11: width of the data-length field (max 2047 bytes).
- TO_CYCLES, 255: cycles without tx_ready in a transmit state before abort (1..255).
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- hs_req  in  1  handshake request; level, held until hs_ack.
- hs_pid  in  2  0 ACK, 1 NAK, 2 STALL, 3 NYET; sampled at hs_ack.
- hs_ack  out  1  one-cycle pulse: request accepted.
- dat_req  in  1  data-packet request; level, held until dat_ack.
- dat_pid  in  2  0 DATA0, 1 DATA1, 2 DATA2, 3 MDATA; sampled at dat_ack.
- dat_len  in  LEN_W  payload bytes; 0 means zero-length packet; sampled at dat_ack.
- dat_ack  out  1  one-cycle pulse: data request accepted.
- pkt_done  out  1  one-cycle pulse: packet (either type) fully transmitted.
- tx_err  out  1  one-cycle pulse: watchdog abort.
- busy  out  1  high in every state except IDLE.
- send_token  out  1  to assembler; one-cycle strobe.
- token_pid_sel  out  2  to assembler; registered handshake PID.
- send_data  out  1  to assembler; level for the duration of payload.
- data_pid_sel  out  2  to assembler; registered data PID.
- send_zero_length  out  1  to assembler; zero-length qualifier.
- rd_next  in  1  from assembler; one pulse per payload byte consumed.
- tx_ready  in  1  UTMI tx_ready.
- tx_valid  in  1  UTMI tx_valid, as driven by the assembler.

## Operation
- All outputs are registered. Reset value of every output is 0, the FSM is in IDLE, and all counters are 0.
- **FSM states:** IDLE, HS, DPRE, DATA, DFLUSH, GAP.
- **IDLE:**
  - hs_req has priority over dat_req.
  - On hs_req: pulse hs_ack, latch token_pid_sel <= hs_pid, assert send_token for one cycle, go to HS.
  - Else on dat_req: pulse dat_ack, latch data_pid_sel <= dat_pid and byte counter cnt <= dat_len, set send_zero_length <= (dat_len == 0), go to DPRE.
- **HS:** wait for tx_ready. On the first cycle with tx_ready, pulse pkt_done and go to GAP.
- **DPRE:** exactly one cycle, so the assembler registers send_zero_length before send_data rises. Assert send_data, go to DATA.
- **DATA:**
  - Each rd_next decrements cnt. cnt never decrements below 0; rd_next at cnt == 0 is ignored.
  - send_data is cleared in the cycle after the rd_next that brings cnt to 0, or in the first DATA cycle when cnt == 0 (zero-length). Then go to DFLUSH.
  - send_zero_length clears together with send_data.
- **DFLUSH:** wait for the falling edge of tx_valid (sampled 1 then 0, CRC bytes sent). Then pulse pkt_done and go to GAP.
- **GAP:** count IPG_CYCLES cycles, then return to IDLE. Requests are not accepted during GAP; they are held by the requester.
- **Watchdog:**
  - Counter runs in HS, DATA and DFLUSH; it clears on tx_ready and on state entry.
  - When it reaches TO_CYCLES: pulse tx_err (no pkt_done), drop send_data and send_zero_length, go to GAP.
- **Simultaneous events:**
  - hs_req and dat_req in the same IDLE cycle: handshake wins; dat_req stays pending.
  - Requests arriving outside IDLE wait for IDLE.
  - rd_next and the watchdog expiry in the same cycle: the abort wins.
- Reset mid-packet: all strobes drop immediately (asynchronous); no pkt_done or tx_err is generated.

## Timing
- Request to strobe: the ack pulse and send_token appear in the same cycle, 1 clock after hs_req is first seen in IDLE.
- send_data rises 2 clocks after dat_req is sampled (ack cycle, then DPRE).
- send_data falls 1 clock after the final rd_next.
- pkt_done is 1 clock after the qualifying tx_ready (HS) or the tx_valid fall (DFLUSH).
- Back-to-back packets: next ack no earlier than IPG_CYCLES+1 clocks after pkt_done.
- busy rises with the ack pulse and falls on the cycle IDLE is re-entered.

## Test plan
- hs_req=1, hs_pid=2, tx_ready 3 cycles later -> hs_ack, one-cycle send_token with token_pid_sel=2; pkt_done 1 clock after tx_ready; busy low after 4 GAP cycles.
- dat_req, dat_pid=1, dat_len=5, five rd_next pulses -> send_data high from DPRE+1; it falls 1 clock after the 5th rd_next; pkt_done after the tx_valid fall; data_pid_sel=1 throughout.
- dat_len=0 -> send_zero_length high in DPRE (1 clock before send_data); send_data high for exactly one cycle; pkt_done on the tx_valid fall.
- hs_req and dat_req asserted together -> handshake sent first; dat_ack no earlier than IPG_CYCLES+1 clocks after its pkt_done.
- DATA with tx_ready held low for 255 cycles -> tx_err pulse, send_data=0, no pkt_done, GAP then IDLE.
- rst asserted low mid-DATA (cnt=3) -> all outputs 0 immediately; after release, a new request is accepted normally.
